pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 16'h0000, PC value loaded on reset and on leaving RESET state.
REQ-002 Parameter STACK_DEPTH, default 4, return-stack entries; legal range 2..8.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  hold PC and stack this cycle.
REQ-006 jump  input  1  load pc from jump_addr.
REQ-007 call  input  1  push pc+1, load pc from jump_addr.
REQ-008 ret  input  1  pop return stack into pc.
REQ-009 branch  input  1  conditional relative branch request.
REQ-010 branch_taken  input  1  branch condition; qualifies branch.
REQ-011 branch_off  input  16  signed two's-complement offset, relative to current pc.
REQ-012 jump_addr  input  16  absolute target for jump/call.
REQ-013 halt  input  1  enter HALT state.
REQ-014 resume  input  1  leave HALT state.
REQ-015 pc  output  16  registered program counter; drives the program counter datapath input.
REQ-016 pc_valid  output  1  high only in RUN state.
REQ-017 halted  output  1  high only in HALT state.
REQ-018 stack_err  output  1  sticky overflow/underflow flag, cleared only by reset.

Function
REQ-019 FSM states: RESET, RUN, HALT; RESET->RUN unconditionally after one clk; RUN->HALT when halt=1; HALT->RUN when resume=1 and halt=0.
REQ-020 In RUN, one action per cycle, priority: halt > stall > ret > call > jump > (branch & branch_taken) > increment.
REQ-021 halt in RUN: pc holds, stack holds, next state HALT.
REQ-022 stall: pc, stack, depth hold; all other control inputs ignored.
REQ-023 ret with depth>0: pc <= top entry, depth decrements.
REQ-024 ret with depth=0: stack_err <= 1, pc <= pc+1 (treated as increment).
REQ-025 call with depth<STACK_DEPTH: push pc+1 (mod 2^16), depth increments, pc <= jump_addr.
REQ-026 call with depth=STACK_DEPTH: stack_err <= 1, no push, pc <= jump_addr.
REQ-027 jump: pc <= jump_addr.
REQ-028 branch & branch_taken: pc <= pc + branch_off, modulo 2^16; branch with branch_taken=0 = increment.
REQ-029 Increment: pc <= pc+1; 16'hFFFF wraps to 16'h0000, no flag.
REQ-030 In HALT: pc, stack, depth hold; all inputs except halt/resume ignored.
REQ-031 Latency: pc reflects an action on the clk edge where the action is sampled; no additional pipeline stage.
REQ-032 pc_valid, halted are decoded from registered state only (no combinational path from inputs).

Reset
REQ-033 rst_n=0 asynchronously forces: state=RESET, pc=RESET_VEC, depth=0, stack_err=0, pc_valid=0, halted=0.
REQ-034 Stack entry contents are don't-care after reset; never observable because depth=0.
REQ-035 First RUN cycle presents pc=RESET_VEC with pc_valid=1; increment begins next edge.
REQ-036 rst_n asserted mid-call/ret or in HALT: same reset values; no partial push/pop survives.

Verification
REQ-037 Reset release, no control for 4 cycles -> pc 0000(valid=0),0000,0001,0002,0003.
REQ-038 pc=0010, call jump_addr=0100; then ret -> pc=0100, then 0011; depth back to 0, stack_err=0.
REQ-039 pc=0020, branch=1 taken=1 off=FFFC -> pc=001C; taken=0 -> pc=0021.
REQ-040 Four calls then fifth call jump_addr=0200 (depth 4) -> pc=0200, stack_err=1, subsequent ret returns fourth pushed address.
REQ-041 pc=FFFF increment -> 0000; stall=1 with jump=1 -> pc holds; halt then resume -> halted=1 one-plus cycles, pc unchanged, then increments.
REQ-042 ret at depth 0 from pc=0005 -> pc=0006, stack_err=1; rst_n pulse mid-stream -> pc=RESET_VEC, stack_err=0 immediately.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between an instruction-issue controller (master)
// and the program-counter sequencer (slave).
interface pc_sequencer_if;
   logic        stall;
   logic        jump;
   logic        call;
   logic        ret;
   logic        branch;
   logic        branch_taken;
   logic [15:0] branch_off;
   logic [15:0] jump_addr;
   logic        halt;
   logic        resume;
   logic [15:0] pc;
   logic        pc_valid;
   logic        halted;
   logic        stack_err;

   modport master (
      output stall, jump, call, ret, branch, branch_taken, branch_off, jump_addr, halt, resume,
      input  pc, pc_valid, halted, stack_err
   );

   modport slave (
      input  stall, jump, call, ret, branch, branch_taken, branch_off, jump_addr, halt, resume,
      output pc, pc_valid, halted, stack_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, jump, call/return with a small
// return stack, relative branches, stall and halt/resume control.
// STACK_DEPTH must lie in 2..8.
module pc_sequencer #(
   parameter logic [15:0] RESET_VEC   = 16'h0000,
   parameter int unsigned STACK_DEPTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   pc_sequencer_if.slave bus
);

   localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IdxW   = $clog2(STACK_DEPTH);

   typedef enum logic [1:0] {StReset, StRun, StHalt} state_e;

   state_e            state_q, state_d;
   logic [15:0]       pc_q, pc_d;
   logic [DepthW-1:0] depth_q, depth_d;
   logic              err_q, err_d;
   logic [15:0]       stack_q [2**IdxW];

   logic              push_en;
   logic [IdxW-1:0]   push_idx;
   logic [IdxW-1:0]   top_idx;
   logic [15:0]       pc_inc;

   // Next-state decode: one action per RUN cycle in fixed priority order.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      depth_d  = depth_q;
      err_d    = err_q;
      push_en  = 1'b0;
      pc_inc   = pc_q + 16'd1;
      // Only meaningful when depth is in range; out-of-range indices are never used.
      top_idx  = IdxW'(depth_q - DepthW'(1));
      push_idx = IdxW'(depth_q);

      case (state_q)
         StReset: begin
            state_d = StRun;
            pc_d    = RESET_VEC;
         end
         StRun: begin
            if (bus.halt) begin
               state_d = StHalt;
            end else if (bus.stall) begin
               state_d = StRun;
            end else if (bus.ret) begin
               if (depth_q != '0) begin
                  pc_d    = stack_q[top_idx];
                  depth_d = depth_q - DepthW'(1);
               end else begin
                  // Underflow behaves as a plain increment.
                  err_d = 1'b1;
                  pc_d  = pc_inc;
               end
            end else if (bus.call) begin
               if (depth_q != DepthW'(STACK_DEPTH)) begin
                  push_en = 1'b1;
                  depth_d = depth_q + DepthW'(1);
               end else begin
                  err_d = 1'b1;
               end
               pc_d = bus.jump_addr;
            end else if (bus.jump) begin
               pc_d = bus.jump_addr;
            end else if (bus.branch && bus.branch_taken) begin
               pc_d = pc_q + bus.branch_off;
            end else begin
               pc_d = pc_inc;
            end
         end
         StHalt: begin
            if (bus.resume && !bus.halt) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StReset;
         end
      endcase
   end

   // Control state, PC, stack depth and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StReset;
         pc_q    <= RESET_VEC;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

   // Return-stack storage; contents need no reset since depth gates every read.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_q[push_idx] <= pc_inc;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_valid  = (state_q == StRun);
   assign bus.halted    = (state_q == StHalt);
   assign bus.stack_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized control traffic, all compared against a queue-based model.
module tb_pc_sequencer;

   localparam logic [15:0] ResetVec = 16'h0000;
   localparam int unsigned Depth    = 4;

   logic clk = 1'b0;
   logic rst_n;

   pc_sequencer_if bus ();

   pc_sequencer #(
      .RESET_VEC   (ResetVec),
      .STACK_DEPTH (Depth)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: mode 0 = reset, 1 = running, 2 = halted.
   int          m_mode;
   logic [15:0] m_pc;
   logic [15:0] m_stack[$];
   logic        m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_pc   = ResetVec;
      m_err  = 1'b0;
      m_stack.delete();
   endtask

   task automatic model_step();
      case (m_mode)
         0: begin
            m_mode = 1;
            m_pc   = ResetVec;
         end
         1: begin
            if (bus.halt) m_mode = 2;
            else if (bus.stall) m_pc = m_pc;
            else if (bus.ret) begin
               if (m_stack.size() > 0) m_pc = m_stack.pop_back();
               else begin
                  m_err = 1'b1;
                  m_pc  = m_pc + 16'd1;
               end
            end else if (bus.call) begin
               if (m_stack.size() < Depth) m_stack.push_back(m_pc + 16'd1);
               else m_err = 1'b1;
               m_pc = bus.jump_addr;
            end else if (bus.jump) m_pc = bus.jump_addr;
            else if (bus.branch && bus.branch_taken) m_pc = m_pc + bus.branch_off;
            else m_pc = m_pc + 16'd1;
         end
         default: begin
            if (bus.resume && !bus.halt) m_mode = 1;
         end
      endcase
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_pc"},     {16'd0, bus.pc},    {16'd0, m_pc});
      check({tag, "_valid"},  {31'd0, bus.pc_valid}, {31'd0, (m_mode == 1)});
      check({tag, "_halted"}, {31'd0, bus.halted},   {31'd0, (m_mode == 2)});
      check({tag, "_err"},    {31'd0, bus.stack_err}, {31'd0, m_err});
   endtask

   task automatic idle();
      bus.stall        = 1'b0;
      bus.jump         = 1'b0;
      bus.call         = 1'b0;
      bus.ret          = 1'b0;
      bus.branch       = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_off   = 16'h0000;
      bus.jump_addr    = 16'h0000;
      bus.halt         = 1'b0;
      bus.resume       = 1'b0;
   endtask

   // Inputs are stable before the edge; outputs sampled 1 time unit after it.
   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      compare_all(tag);
   endtask

   task automatic do_jump(input logic [15:0] addr);
      idle();
      bus.jump      = 1'b1;
      bus.jump_addr = addr;
      tick("jmp");
   endtask

   // Asynchronous reset asserted mid-cycle, checked before any clock edge.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("arst");
      check("arst_pc_now", {16'd0, bus.pc}, {16'd0, ResetVec});
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      idle();
      model_reset();
      rst_n = 1'b0;
      #1;
      compare_all("por");
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("r037_pc0", {16'd0, bus.pc}, 32'h0000);
      check("r037_v0", {31'd0, bus.pc_valid}, 32'd0);

      // Idle after reset release: 0000, 0001, 0002, 0003.
      tick("r037a");
      check("r037_pc1", {16'd0, bus.pc}, 32'h0000);
      check("r037_v1", {31'd0, bus.pc_valid}, 32'd1);
      tick("r037b");
      check("r037_pc2", {16'd0, bus.pc}, 32'h0001);
      tick("r037c");
      check("r037_pc3", {16'd0, bus.pc}, 32'h0002);
      tick("r037d");
      check("r037_pc4", {16'd0, bus.pc}, 32'h0003);

      // Call then return.
      do_jump(16'h0010);
      idle(); bus.call = 1'b1; bus.jump_addr = 16'h0100;
      tick("r038c");
      check("r038_call", {16'd0, bus.pc}, 32'h0100);
      idle(); bus.ret = 1'b1;
      tick("r038r");
      check("r038_ret", {16'd0, bus.pc}, 32'h0011);
      check("r038_err", {31'd0, bus.stack_err}, 32'd0);

      // Relative branches, taken and not taken.
      do_jump(16'h0020);
      idle(); bus.branch = 1'b1; bus.branch_taken = 1'b1; bus.branch_off = 16'hFFFC;
      tick("r039t");
      check("r039_taken", {16'd0, bus.pc}, 32'h001C);
      do_jump(16'h0020);
      idle(); bus.branch = 1'b1; bus.branch_taken = 1'b0; bus.branch_off = 16'hFFFC;
      tick("r039n");
      check("r039_ntaken", {16'd0, bus.pc}, 32'h0021);

      // Fill the stack, overflow, then return to the fourth pushed address.
      do_jump(16'h0030);
      for (int i = 0; i < 4; i++) begin
         idle(); bus.call = 1'b1; bus.jump_addr = 16'h0300 + 16'(i) * 16'h0100;
         tick("r040c");
      end
      idle(); bus.call = 1'b1; bus.jump_addr = 16'h0200;
      tick("r040o");
      check("r040_ovf_pc", {16'd0, bus.pc}, 32'h0200);
      check("r040_ovf_err", {31'd0, bus.stack_err}, 32'd1);
      idle(); bus.ret = 1'b1;
      tick("r040r");
      check("r040_ret", {16'd0, bus.pc}, 32'h0501);

      // Wrap, stall priority over jump, halt/resume.
      do_jump(16'hFFFF);
      idle();
      tick("r041w");
      check("r041_wrap", {16'd0, bus.pc}, 32'h0000);
      idle(); bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_addr = 16'h1234;
      tick("r041s");
      check("r041_stall", {16'd0, bus.pc}, 32'h0000);
      idle(); bus.halt = 1'b1;
      tick("r041h1");
      check("r041_halted", {31'd0, bus.halted}, 32'd1);
      idle(); bus.halt = 1'b1; bus.jump = 1'b1; bus.jump_addr = 16'h4321;
      tick("r041h2");
      check("r041_hold", {16'd0, bus.pc}, 32'h0000);
      idle(); bus.resume = 1'b1;
      tick("r041r");
      check("r041_res_pc", {16'd0, bus.pc}, 32'h0000);
      check("r041_res_h", {31'd0, bus.halted}, 32'd0);
      idle();
      tick("r041i");
      check("r041_inc", {16'd0, bus.pc}, 32'h0001);

      // Underflow, then a reset pulse clears the sticky flag.
      async_reset();
      idle();
      tick("r042a");
      do_jump(16'h0005);
      idle(); bus.ret = 1'b1;
      tick("r042u");
      check("r042_pc", {16'd0, bus.pc}, 32'h0006);
      check("r042_err", {31'd0, bus.stack_err}, 32'd1);
      async_reset();
      check("r042_clr", {31'd0, bus.stack_err}, 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset();
         end else begin
            idle();
            bus.halt         = ($urandom_range(0, 19) == 0);
            bus.resume       = ($urandom_range(0, 3) == 0);
            bus.stall        = ($urandom_range(0, 7) == 0);
            bus.ret          = ($urandom_range(0, 5) == 0);
            bus.call         = ($urandom_range(0, 5) == 0);
            bus.jump         = ($urandom_range(0, 7) == 0);
            bus.branch       = ($urandom_range(0, 3) == 0);
            bus.branch_taken = 1'($urandom);
            bus.branch_off   = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                            : 16'($urandom_range(0, 15)) - 16'd8;
            bus.jump_addr    = 16'($urandom);
            tick("rnd");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
